// File: rtl/filter_step_history.sv
// rtl/filter_step_history.sv - edge history, per-tap PWL offsets and step superposition
// Optional output saturation: FILTER_HIST_SAT_EN (default build wraps to OUT_WIDTH).
module filter_step_history #(
  parameter int                            N_TAPS      = 8,
  parameter int                            TIME_WIDTH  = 32,
  parameter int                            DT_WIDTH    = 16,
  parameter logic [DT_WIDTH-1:0]           DT_MAX      = 16'd50000,
  parameter int                            STEP_WIDTH  = 18,
  parameter logic signed [STEP_WIDTH-1:0]  STEP_FINAL  = 18'sd0,
  parameter int                            OUT_WIDTH   = 24,
  parameter int                            PWL_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [TIME_WIDTH-1:0]          time_now,
  input  logic                           edge_valid,
  input  logic [TIME_WIDTH-1:0]          edge_time,
  input  logic                           edge_bit,
  output logic [N_TAPS*DT_WIDTH-1:0]     dt_out,
  input  logic [N_TAPS*STEP_WIDTH-1:0]   step_in,
  output logic [OUT_WIDTH-1:0]           out,
  output logic                           out_valid,
  output logic                           overflow
);

  localparam int PTR_W = $clog2(N_TAPS);
  localparam int EXT_W = OUT_WIDTH + PTR_W;
  localparam int PIPE  = 1 + PWL_LATENCY;
  localparam int VLD   = 2 + PWL_LATENCY;

  localparam logic [TIME_WIDTH-1:0]    DT_MAX_T = TIME_WIDTH'(DT_MAX);
  localparam logic signed [EXT_W-1:0]  FOLD     = EXT_W'(STEP_FINAL);
  localparam logic signed [EXT_W-1:0]  OUT_MAX  = {{(PTR_W+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0]  OUT_MIN  = ~OUT_MAX;

  logic [N_TAPS-1:0][TIME_WIDTH-1:0] slot_time_q, slot_time_d;
  logic [N_TAPS-1:0]                 slot_sign_q, slot_sign_d;
  logic [N_TAPS-1:0]                 slot_live_q, slot_live_d;
  logic [PTR_W-1:0]                  wr_ptr_q, wr_ptr_d;
  logic signed [EXT_W-1:0]           dc_q, dc_d;
  logic [N_TAPS-1:0][DT_WIDTH-1:0]   dt_q, dt_d;
  logic [PIPE-1:0][N_TAPS-1:0]       mask_pipe_q, mask_pipe_d;
  logic [PIPE-1:0][N_TAPS-1:0]       sign_pipe_q, sign_pipe_d;
  logic [PIPE-1:0][EXT_W-1:0]        dc_pipe_q, dc_pipe_d;
  logic [OUT_WIDTH-1:0]              out_q, out_d;
  logic [VLD-1:0]                    vld_q, vld_d;
  logic                              overflow_q, overflow_d;

  logic [N_TAPS-1:0][TIME_WIDTH-1:0] dt_full;
  logic [N_TAPS-1:0]                 retire;
  logic [N_TAPS-1:0]                 mask_now;
  logic signed [EXT_W-1:0]           dc_acc;
  logic signed [EXT_W-1:0]           step_ext;
  logic signed [EXT_W-1:0]           sum;
  logic                              sum_ovf;

  always_comb begin
    slot_time_d = slot_time_q;
    slot_sign_d = slot_sign_q;
    slot_live_d = slot_live_q;
    wr_ptr_d    = wr_ptr_q;
    dt_full     = '0;
    retire      = '0;
    mask_now    = '0;
    dt_d        = '0;
    dc_acc      = dc_q;

    // An overwritten live slot folds like an expired one; OR-ing keeps it to one fold.
    for (int k = 0; k < N_TAPS; k++) begin
      dt_full[k]  = time_now - slot_time_q[k];
      retire[k]   = slot_live_q[k] &&
                    ((dt_full[k] >= DT_MAX_T) || (edge_valid && (wr_ptr_q == PTR_W'(k))));
      mask_now[k] = slot_live_q[k] && !retire[k];
      dt_d[k]     = slot_live_q[k] ? dt_full[k][DT_WIDTH-1:0] : '0;
      if (retire[k]) begin
        slot_live_d[k] = 1'b0;
        dc_acc = slot_sign_q[k] ? dc_acc + FOLD : dc_acc - FOLD;
      end
    end

    if (edge_valid) begin
      slot_time_d[wr_ptr_q] = edge_time;
      slot_sign_d[wr_ptr_q] = edge_bit;
      slot_live_d[wr_ptr_q] = 1'b1;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    dc_d = dc_acc;

    mask_pipe_d[0] = mask_now;
    sign_pipe_d[0] = slot_sign_q;
    dc_pipe_d[0]   = dc_acc;
    for (int i = 1; i < PIPE; i++) begin
      mask_pipe_d[i] = mask_pipe_q[i-1];
      sign_pipe_d[i] = sign_pipe_q[i-1];
      dc_pipe_d[i]   = dc_pipe_q[i-1];
    end

    sum      = $signed(dc_pipe_q[PIPE-1]);
    step_ext = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      step_ext = EXT_W'($signed(step_in[k*STEP_WIDTH +: STEP_WIDTH]));
      if (mask_pipe_q[PIPE-1][k]) begin
        sum = sign_pipe_q[PIPE-1][k] ? sum + step_ext : sum - step_ext;
      end
    end

    sum_ovf    = (sum > OUT_MAX) || (sum < OUT_MIN);
    overflow_d = overflow_q | sum_ovf;
`ifdef FILTER_HIST_SAT_EN
    if (sum_ovf) begin
      out_d = sum[EXT_W-1] ? OUT_MIN[OUT_WIDTH-1:0] : OUT_MAX[OUT_WIDTH-1:0];
    end else begin
      out_d = sum[OUT_WIDTH-1:0];
    end
`else
    out_d = sum[OUT_WIDTH-1:0];
`endif
    vld_d = {vld_q[VLD-2:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_time_q <= '0;
      slot_sign_q <= '0;
      slot_live_q <= '0;
      wr_ptr_q    <= '0;
      dc_q        <= '0;
      dt_q        <= '0;
      mask_pipe_q <= '0;
      sign_pipe_q <= '0;
      dc_pipe_q   <= '0;
      out_q       <= '0;
      vld_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      slot_time_q <= slot_time_d;
      slot_sign_q <= slot_sign_d;
      slot_live_q <= slot_live_d;
      wr_ptr_q    <= wr_ptr_d;
      dc_q        <= dc_d;
      dt_q        <= dt_d;
      mask_pipe_q <= mask_pipe_d;
      sign_pipe_q <= sign_pipe_d;
      dc_pipe_q   <= dc_pipe_d;
      out_q       <= out_d;
      vld_q       <= vld_d;
      overflow_q  <= overflow_d;
    end
  end

  assign dt_out    = dt_q;
  assign out       = out_q;
  assign out_valid = vld_q[VLD-1];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_filter_step_history.sv
// tb/tb_filter_step_history.sv - scoreboard bench for filter_step_history with a registered PWL model
module tb_filter_step_history;
  localparam int NT = 4;
  localparam int DW = 16;
  localparam int SW = 18;
  localparam int OW = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [31:0]         time_now;
  logic                edge_valid;
  logic [31:0]         edge_time;
  logic                edge_bit;
  logic [NT*DW-1:0]    dt_out;
  logic [NT*SW-1:0]    step_in;
  logic [OW-1:0]       out;
  logic                out_valid;
  logic                overflow;

  always #5 clk = ~clk;

  filter_step_history #(
    .N_TAPS(NT), .TIME_WIDTH(32), .DT_WIDTH(DW), .DT_MAX(16'd1000),
    .STEP_WIDTH(SW), .STEP_FINAL(18'sd100), .OUT_WIDTH(OW), .PWL_LATENCY(1)
  ) dut (
    .clk(clk), .rst(rst), .time_now(time_now), .edge_valid(edge_valid),
    .edge_time(edge_time), .edge_bit(edge_bit), .dt_out(dt_out), .step_in(step_in),
    .out(out), .out_valid(out_valid), .overflow(overflow)
  );

  function automatic int pwl(input logic [15:0] d);
    int v;
    v = int'(d) / 10;
    return (v > 100) ? 100 : v;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < NT; k++) begin
      if (rst) step_in[k*SW +: SW] <= '0;
      else     step_in[k*SW +: SW] <= SW'(pwl(dt_out[k*DW +: DW]));
    end
  end

  typedef struct { logic [OW-1:0] o; bit ov; } exp_t;
  exp_t              out_q[$];
  logic [NT*DW-1:0]  dt_q[$];
  logic [31:0]       m_time[NT];
  bit                m_sign[NT];
  bit                m_live[NT];
  int                m_ptr;
  int                m_dc;
  bit                m_ov;
  int                n_cmp = 0;
  int                n_bad = 0;

  task automatic apply_reset();
    rst = 1'b1; edge_valid = 1'b0; time_now = '0; edge_time = '0; edge_bit = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NT; k++) begin m_live[k] = 1'b0; m_sign[k] = 1'b0; m_time[k] = '0; end
    m_ptr = 0; m_dc = 0; m_ov = 1'b0;
    out_q.delete(); dt_q.delete();
  endtask

  task automatic drive(input logic [31:0] tn, input bit ev, input logic [31:0] et, input bit eb);
    logic [NT*DW-1:0] dte;
    logic [31:0]      d;
    logic [31:0]      s;
    int               sum;
    exp_t             e;
    logic [NT*DW-1:0] dexp;
    time_now = tn; edge_valid = ev; edge_time = et; edge_bit = eb;
    dte = '0; sum = 0;
    for (int k = 0; k < NT; k++) begin
      if (m_live[k]) begin
        d = tn - m_time[k];
        dte[k*DW +: DW] = d[15:0];
        if (d >= 32'd1000 || (ev && k == m_ptr)) begin
          m_live[k] = 1'b0;
          m_dc += m_sign[k] ? 100 : -100;
        end else begin
          sum += (m_sign[k] ? 1 : -1) * pwl(d[15:0]);
        end
      end
    end
    if (ev) begin
      m_time[m_ptr] = et; m_sign[m_ptr] = eb; m_live[m_ptr] = 1'b1;
      m_ptr = (m_ptr + 1) % NT;
    end
    sum += m_dc;
    if (sum > 127 || sum < -128) m_ov = 1'b1;
    s = sum;
`ifdef FILTER_HIST_SAT_EN
    e.o = (sum > 127) ? 8'h7F : (sum < -128) ? 8'h80 : s[7:0];
`else
    e.o = s[7:0];
`endif
    e.ov = m_ov;
    out_q.push_back(e);
    dt_q.push_back(dte);
    @(negedge clk);
    dexp = dt_q.pop_front();
    n_cmp++;
    if (dt_out !== dexp) begin
      n_bad++; $display("FAIL dt_out: got %h expected %h", dt_out, dexp);
    end
    if (out_q.size() == 3) begin
      e = out_q.pop_front();
      n_cmp++;
      if (out !== e.o) begin
        n_bad++; $display("FAIL out: got %0d expected %0d", $signed(out), $signed(e.o));
      end
      n_cmp++;
      if (overflow !== e.ov) begin
        n_bad++; $display("FAIL overflow: got %b expected %b", overflow, e.ov);
      end
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_bad++; $display("FAIL out_valid_high: got %b expected 1", out_valid);
      end
    end else begin
      n_cmp++;
      if (out_valid !== 1'b0 || out !== '0 || overflow !== 1'b0) begin
        n_bad++; $display("FAIL pre_valid: got valid=%b out=%0d ovf=%b expected 0 0 0", out_valid, out, overflow);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (dt_out !== '0 || out !== '0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      n_bad++; $display("FAIL reset_values: got dt=%h out=%0d valid=%b ovf=%b expected all 0", dt_out, out, out_valid, overflow);
    end
    for (int i = 0; i < 8; i++) drive(32'(10 * i), 1'b0, '0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out !== '0) begin
      n_bad++; $display("FAIL idle_ramp: got valid=%b out=%0d expected 1 0", out_valid, out);
    end
  endtask

  task automatic test_single_edge();
    apply_reset();
    drive(32'd0, 1'b1, 32'd0, 1'b1);
    for (int i = 0; i <= 10; i++) drive(32'(100 * i), 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) drive(32'd1100, 1'b0, '0, 1'b0);
    n_cmp++;
    if (out !== 8'd100 || dt_out !== '0) begin
      n_bad++; $display("FAIL retire_dc: got out=%0d dt=%h expected 100 0", out, dt_out);
    end
  endtask

  task automatic test_two_edges();
    apply_reset();
    drive(32'd0, 1'b1, 32'd0, 1'b1);
    drive(32'd200, 1'b1, 32'd200, 1'b0);
    for (int i = 0; i < 3; i++) drive(32'd500, 1'b0, '0, 1'b0);
    n_cmp++;
    if (out !== 8'd20) begin
      n_bad++; $display("FAIL two_edges: got %0d expected 20", $signed(out));
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 5; i++) drive(32'd10, 1'b1, 32'(i), 1'b1);
    for (int i = 0; i < 3; i++) drive(32'd10, 1'b0, '0, 1'b0);
    n_cmp++;
    if (dt_out[15:0] !== 16'd6 || out !== 8'd100) begin
      n_bad++; $display("FAIL back_to_back: got dt0=%0d out=%0d expected 6 100", dt_out[15:0], out);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    drive(32'hFFFF_FFCE, 1'b1, 32'hFFFF_FFCE, 1'b1);
    for (int i = 0; i < 3; i++) drive(32'd50, 1'b0, '0, 1'b0);
    n_cmp++;
    if (dt_out[15:0] !== 16'd100 || out !== 8'd10) begin
      n_bad++; $display("FAIL time_wrap: got dt0=%0d out=%0d expected 100 10", dt_out[15:0], out);
    end
  endtask

  task automatic test_overflow();
    logic [OW-1:0] want;
`ifdef FILTER_HIST_SAT_EN
    want = 8'h7F;
`else
    want = 8'hC8;
`endif
    apply_reset();
    drive(32'd0, 1'b1, 32'd0, 1'b1);
    drive(32'd0, 1'b1, 32'd1, 1'b1);
    for (int i = 0; i < 3; i++) drive(32'd2000, 1'b0, '0, 1'b0);
    n_cmp++;
    if (out !== want || overflow !== 1'b1) begin
      n_bad++; $display("FAIL overflow_out: got out=%0d ovf=%b expected %0d 1", $signed(out), overflow, $signed(want));
    end
    apply_reset();
    n_cmp++;
    if (overflow !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL overflow_clear: got ovf=%b valid=%b expected 0 0", overflow, out_valid);
    end
  endtask

  initial begin
    rst = 1'b1; edge_valid = 1'b0; time_now = '0; edge_time = '0; edge_bit = 1'b0;
    test_reset();
    test_single_edge();
    test_two_edges();
    test_back_to_back();
    test_wrap();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
